// File: rtl/peak_readout_sequencer.sv
// Drains fixed-length records from a byte FIFO to a transmitter, each framed by a header byte.
// Define PEAK_READOUT_CHECKSUM_EN to append an XOR checksum byte after each record.
module peak_readout_sequencer #(
    parameter int unsigned RECORD_BYTES  = 512,
    parameter logic [7:0]  HEADER_BYTE   = 8'hAA,
    parameter int unsigned VALID_TIMEOUT = 4
) (
    input  logic        SysClk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        ClearStatus,
    input  logic        DataAvailable,
    input  logic        DataValid,
    input  logic [7:0]  DataIn,
    output logic        DataRead,
    input  logic        TxBusy,
    output logic        TxWrite,
    output logic [7:0]  TxData,
    output logic        Busy,
    output logic        RecordDone,
    output logic        Underrun,
    output logic [15:0] RecordCount
);

    localparam int unsigned        TMO_W     = $clog2(VALID_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(VALID_TIMEOUT);
    localparam logic [15:0]        LAST_BYTE = 16'(RECORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_REQ, ST_WAIT, ST_SEND, ST_CSUM, ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [15:0]      record_count_q, record_count_d;
    logic             data_read_q, data_read_d;
    logic             tx_write_q, tx_write_d;
    logic             busy_q, busy_d;
    logic             record_done_q, record_done_d;
    logic             underrun_q, underrun_d;
    logic             timeout;
`ifdef PEAK_READOUT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        tmo_d          = tmo_q;
        data_d         = data_q;
        tx_data_d      = tx_data_q;
        record_count_d = record_count_q;
        data_read_d    = 1'b0;
        tx_write_d     = 1'b0;
        record_done_d  = 1'b0;
        timeout        = 1'b0;
`ifdef PEAK_READOUT_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Enable && DataAvailable) begin
                    state_d    = ST_HDR;
                    byte_cnt_d = '0;
`ifdef PEAK_READOUT_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_HDR: begin
                if (!TxBusy) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = HEADER_BYTE;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (DataAvailable) begin
                    data_read_d = 1'b1;
                    tmo_d       = TMO_LOAD;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // tmo_q counts down the WAIT cycles left, including the current one
                if (DataValid) begin
                    data_d  = DataIn;
                    state_d = ST_SEND;
                end else if (tmo_q <= TMO_W'(1)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_SEND: begin
                if (!TxBusy) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = data_q;
                    byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef PEAK_READOUT_CHECKSUM_EN
                    csum_d     = csum_q ^ data_q;
                    state_d    = (byte_cnt_d == LAST_BYTE) ? ST_CSUM : ST_REQ;
`else
                    state_d    = (byte_cnt_d == LAST_BYTE) ? ST_DONE : ST_REQ;
`endif
                end
            end
            ST_CSUM: begin
`ifdef PEAK_READOUT_CHECKSUM_EN
                if (!TxBusy) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = csum_q;
                    state_d    = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                record_done_d  = 1'b1;
                record_count_d = record_count_q + 16'd1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // a timeout in the same cycle as ClearStatus must leave the flag set
        underrun_d = timeout | (underrun_q & ~ClearStatus);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            tmo_q          <= '0;
            data_q         <= '0;
            tx_data_q      <= '0;
            record_count_q <= '0;
            data_read_q    <= 1'b0;
            tx_write_q     <= 1'b0;
            busy_q         <= 1'b0;
            record_done_q  <= 1'b0;
            underrun_q     <= 1'b0;
`ifdef PEAK_READOUT_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            tmo_q          <= tmo_d;
            data_q         <= data_d;
            tx_data_q      <= tx_data_d;
            record_count_q <= record_count_d;
            data_read_q    <= data_read_d;
            tx_write_q     <= tx_write_d;
            busy_q         <= busy_d;
            record_done_q  <= record_done_d;
            underrun_q     <= underrun_d;
`ifdef PEAK_READOUT_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign DataRead    = data_read_q;
    assign TxWrite     = tx_write_q;
    assign TxData      = tx_data_q;
    assign Busy        = busy_q;
    assign RecordDone  = record_done_q;
    assign Underrun    = underrun_q;
    assign RecordCount = record_count_q;

endmodule

// File: tb/tb_peak_readout_sequencer.sv
// Directed bench for peak_readout_sequencer: 4-byte records, header AA, 4-cycle valid timeout.
module tb_peak_readout_sequencer;

    logic        SysClk = 1'b0;
    logic        Reset, Enable, ClearStatus, DataAvailable, DataValid, TxBusy;
    logic [7:0]  DataIn;
    logic        DataRead, TxWrite, Busy, RecordDone, Underrun;
    logic [7:0]  TxData;
    logic [15:0] RecordCount;

    peak_readout_sequencer #(.RECORD_BYTES(4), .HEADER_BYTE(8'hAA), .VALID_TIMEOUT(4)) dut (
        .SysClk(SysClk), .Reset(Reset), .Enable(Enable), .ClearStatus(ClearStatus),
        .DataAvailable(DataAvailable), .DataValid(DataValid), .DataIn(DataIn),
        .DataRead(DataRead), .TxBusy(TxBusy), .TxWrite(TxWrite), .TxData(TxData),
        .Busy(Busy), .RecordDone(RecordDone), .Underrun(Underrun), .RecordCount(RecordCount)
    );

    always #5 SysClk = ~SysClk;

`ifdef PEAK_READOUT_CHECKSUM_EN
    localparam int EXP_N = 6;
`else
    localparam int EXP_N = 5;
`endif
    logic [7:0] exp_seq [6] = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model (one-cycle read latency) and bus monitor, all on the falling edge
    logic [7:0] fifo [$];
    logic [7:0] tx_log [$];
    logic       pend = 1'b0, pend_kill = 1'b0, und_prev = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    int cyc = 0, reads = 0, dones = 0, overlap = 0, und_rises = 0;
    int kill_at = 0, kill_cyc = 0, und_cyc = 0, last_tx_cyc = 0, done_cyc = 0;

    always @(negedge SysClk) begin
        cyc++;
        DataValid = pend && !pend_kill;
        DataIn    = DataValid ? pend_byte : 8'h00;
        pend      = 1'b0;
        if (DataRead) begin
            reads++;
            pend      = 1'b1;
            pend_kill = (kill_at != 0) && (reads == kill_at);
            if (pend_kill) kill_cyc = cyc;
            pend_byte = (fifo.size() != 0) ? fifo.pop_front() : 8'hEE;
        end
        DataAvailable = (fifo.size() != 0);
        if (TxWrite) begin tx_log.push_back(TxData); last_tx_cyc = cyc; end
        if (RecordDone) begin dones++; done_cyc = cyc; end
        if (DataRead && TxWrite) overlap++;
        if (Underrun && !und_prev) begin und_rises++; und_cyc = cyc; end
        und_prev = Underrun;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge SysClk); #1; end
    endtask

    task automatic push4();
        for (int i = 1; i <= 4; i++) fifo.push_back(8'(i));
    endtask

    task automatic check_seq(input string tag, input int base, input int n);
        chk({tag, "_len"}, tx_log.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < tx_log.size()) chk(tag, tx_log[base + i], exp_seq[i]);
    endtask

    task automatic wait_dones(input string tag, input int target);
        int n = 0;
        while (dones < target && n < 300) begin tick(1); n++; end
        chk(tag, dones, target);
    endtask

    task automatic start_record(input string tag);
        int n = 0;
        Enable = 1'b1;
        while (!Busy && n < 50) begin tick(1); n++; end
        chk(tag, Busy, 1);
        Enable = 1'b0;
    endtask

    int base, r0, d0, t0, n;

    initial begin
        Reset = 1'b1; Enable = 1'b1; ClearStatus = 1'b0; TxBusy = 1'b0;
        DataAvailable = 1'b0; DataValid = 1'b0; DataIn = 8'h00;
        push4();
        tick(4);
        // reset overrides Enable with data available
        chk("rst_dataread", DataRead, 0);
        chk("rst_txwrite", TxWrite, 0);
        chk("rst_txdata", TxData, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", RecordDone, 0);
        chk("rst_underrun", Underrun, 0);
        chk("rst_count", RecordCount, 0);
        Enable = 1'b0; fifo.delete();
        Reset = 1'b0;
        tick(2);

        // plain record
        base = tx_log.size(); r0 = reads;
        push4();
        start_record("r1_start");
        wait_dones("r1_done", 1);
        tick(3);
        check_seq("r1_seq", base, EXP_N);
        chk("r1_count", RecordCount, 1);
        chk("r1_done_gap", done_cyc - last_tx_cyc, 1);
        chk("r1_reads", reads - r0, 4);
        chk("r1_busy", Busy, 0);

        // TxBusy held 10 cycles while the first data byte waits in SEND
        base = tx_log.size(); r0 = reads;
        push4();
        start_record("r2_start");
        n = 0;
        while (reads < r0 + 1 && n < 50) begin tick(1); n++; end
        TxBusy = 1'b1;
        t0 = tx_log.size(); d0 = reads;
        tick(10);
        chk("r2_hold_tx", tx_log.size() - t0, 0);
        chk("r2_hold_rd", reads - d0, 0);
        TxBusy = 1'b0;
        tick(2);
        chk("r2_one_tx", tx_log.size() - t0, 1);
        chk("r2_no_rd", reads - d0, 0);
        wait_dones("r2_done", 2);
        tick(3);
        check_seq("r2_seq", base, EXP_N);
        chk("r2_count", RecordCount, 2);

        // Enable dropped after the header, more data waiting behind the record
        base = tx_log.size();
        push4(); push4();
        Enable = 1'b1;
        n = 0;
        while (tx_log.size() == base && n < 50) begin tick(1); n++; end
        Enable = 1'b0;
        wait_dones("r3_done", 3);
        tick(20);
        check_seq("r3_seq", base, EXP_N);
        chk("r3_count", RecordCount, 3);
        chk("r3_idle", Busy, 0);
        chk("r3_avail", DataAvailable, 1);
        fifo.delete();
        tick(2);

        // DataValid withheld on the 2nd read
        base = tx_log.size(); d0 = dones; t0 = und_rises;
        kill_at = reads + 2;
        push4();
        start_record("u1_start");
        n = 0;
        while (und_rises == t0 && n < 100) begin tick(1); n++; end
        kill_at = 0;
        chk("u1_underrun", Underrun, 1);
        chk("u1_gap", und_cyc - kill_cyc, 4);
        chk("u1_idle", Busy, 0);
        chk("u1_count", RecordCount, 3);
        chk("u1_nodone", dones - d0, 0);
        check_seq("u1_seq", base, 2);
        ClearStatus = 1'b1; tick(1); ClearStatus = 1'b0;
        chk("u1_clear", Underrun, 0);
        fifo.delete();
        tick(2);

        // ClearStatus held through a timeout: set still wins for one cycle
        t0 = und_rises;
        kill_at = reads + 1;
        ClearStatus = 1'b1;
        push4();
        start_record("u2_start");
        n = 0;
        while (und_rises == t0 && n < 100) begin tick(1); n++; end
        kill_at = 0;
        chk("u2_rise", und_rises - t0, 1);
        chk("u2_gap", und_cyc - kill_cyc, 4);
        tick(1);
        chk("u2_cleared", Underrun, 0);
        ClearStatus = 1'b0;
        fifo.delete();
        tick(2);

        // reset while parked in SEND
        push4();
        start_record("rs_start");
        r0 = reads;
        n = 0;
        while (reads < r0 + 1 && n < 50) begin tick(1); n++; end
        TxBusy = 1'b1;
        tick(3);
        Reset = 1'b1;
        tick(1);
        chk("rs_dataread", DataRead, 0);
        chk("rs_txwrite", TxWrite, 0);
        chk("rs_txdata", TxData, 0);
        chk("rs_busy", Busy, 0);
        chk("rs_done", RecordDone, 0);
        chk("rs_count", RecordCount, 0);
        Reset = 1'b0; TxBusy = 1'b0;
        t0 = tx_log.size(); r0 = reads;
        tick(10);
        chk("rs_quiet_tx", tx_log.size() - t0, 0);
        chk("rs_quiet_rd", reads - r0, 0);
        fifo.delete();
        tick(2);

        // RecordCount wrap
        force dut.record_count_q = 16'hFFFF;
        tick(1);
        release dut.record_count_q;
        tick(1);
        chk("wr_preset", RecordCount, 16'hFFFF);
        d0 = dones;
        push4();
        start_record("wr_start");
        wait_dones("wr_done", d0 + 1);
        tick(2);
        chk("wr_count", RecordCount, 16'h0000);
        chk("overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/peak_readout_sequencer.md
PEAK_READOUT_SEQUENCER -- requirements
Module: peak_readout_sequencer

Interface
REQ-001 Parameters SHALL be:
- RECORD_BYTES, 512, bytes drained per record (2..65535).
- HEADER_BYTE, 8'hAA, framing byte sent before each record.
- VALID_TIMEOUT, 4, cycles allowed from DataRead to DataValid.

REQ-002 Ports SHALL be:
- SysClk  in  1  system clock, ~100 MHz; sole clock.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  permits starting a new record.
- ClearStatus  in  1  clears Underrun.
- DataAvailable  in  1  byte FIFO non-empty.
- DataValid  in  1  FIFO read data valid.
- DataIn  in  8  FIFO read data.
- DataRead  out  1  one-cycle FIFO read strobe.
- TxBusy  in  1  transmitter cannot accept a byte.
- TxWrite  out  1  one-cycle byte strobe to transmitter.
- TxData  out  8  byte to transmitter.
- Busy  out  1  high in any state except IDLE.
- RecordDone  out  1  one-cycle pulse at record end.
- Underrun  out  1  sticky DataValid-timeout flag.
- RecordCount  out  16  completed records; wraps 65535->0.

Function
REQ-003 The FSM SHALL have states IDLE, HDR, REQ, WAIT, SEND, CSUM, DONE.
REQ-004 IDLE SHALL go to HDR when Enable=1 and DataAvailable=1 in the same cycle; the byte counter and checksum SHALL clear to 0.
REQ-005 In HDR with TxBusy=0, the block SHALL pulse TxWrite with TxData=HEADER_BYTE and go to REQ; with TxBusy=1 it SHALL hold.
REQ-006 REQ with DataAvailable=1 SHALL pulse DataRead for exactly one cycle, load the timeout counter, and go to WAIT; REQ with DataAvailable=0 SHALL hold with no DataRead.
REQ-007 WAIT with DataValid=1 SHALL latch DataIn and go to SEND.
REQ-008 WAIT with no DataValid for VALID_TIMEOUT cycles SHALL set Underrun and go to IDLE; that record SHALL NOT be counted and RecordDone SHALL NOT pulse.
REQ-009 SEND with TxBusy=0 SHALL pulse TxWrite with the latched byte, XOR the byte into the checksum, and increment the byte counter.
REQ-010 From SEND, if the byte just sent is byte RECORD_BYTES, the FSM SHALL go to CSUM (or DONE per REQ-016); otherwise it SHALL go to REQ.
REQ-011 DONE SHALL pulse RecordDone for one cycle, increment RecordCount modulo 2^16, and go to IDLE.
REQ-012 Deasserting Enable mid-record SHALL NOT abort; the record SHALL complete and no new record SHALL start.
REQ-013 DataRead and TxWrite SHALL never be asserted in the same cycle.
REQ-014 At most one FIFO read SHALL be outstanding at a time.
REQ-015 If ClearStatus=1 and a timeout occur in the same cycle, Underrun SHALL be 1 (set wins).

Configuration
REQ-016 With macro PEAK_READOUT_CHECKSUM_EN defined, CSUM SHALL wait for TxBusy=0, then pulse TxWrite with the 8-bit XOR of all record data bytes (header excluded) and go to DONE.
REQ-017 Without PEAK_READOUT_CHECKSUM_EN, CSUM SHALL be unreachable, no checksum logic SHALL be built, and SEND SHALL go directly to DONE after the last byte.

Reset
REQ-018 On Reset=1 at a SysClk edge, the FSM SHALL enter IDLE and DataRead, TxWrite, Busy, RecordDone, Underrun, RecordCount, TxData, the counters and the checksum SHALL all be 0; Reset SHALL override every other input.
REQ-019 Reset mid-record SHALL abandon the record with no further strobes; FIFO contents are not this block's concern.

Verification
REQ-020 The bench SHALL cover:
- RECORD_BYTES=4, checksum on, FIFO bytes 01,02,03,04, TxBusy=0 -> TxData sequence AA,01,02,03,04,04; one RecordDone; RecordCount=1.
- Same stimulus, checksum off -> sequence AA,01,02,03,04; RecordDone one cycle after the last TxWrite.
- TxBusy held high for 10 cycles during SEND -> TxWrite withheld, then exactly one TxWrite; no extra DataRead.
- DataValid suppressed after the 2nd DataRead -> Underrun=1 after 4 cycles, FSM in IDLE, RecordCount unchanged; ClearStatus -> Underrun=0.
- Enable dropped after the header -> full record completes; with DataAvailable=1, no new HDR.
- Reset asserted in SEND -> next cycle all outputs 0 and Busy=0; RecordCount preset to FFFF and one record completed -> 0000.
